// File: rtl/global_avg_pool_collect.sv
// Global average pooling collector: accumulates a channel-interleaved pixel stream per channel,
// then divides each sum by N via a reciprocal multiply, one channel per cycle.
module global_avg_pool_collect #(
  parameter int WIDTH        = 16,
  parameter int FRAC         = 8,
  parameter int CHANNELS     = 64,
  parameter int FEATURE_SIZE = 7,
  parameter int RECIP_SHIFT  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic signed [WIDTH-1:0] data_in,
  input  logic                    valid_in,
  output logic                    ready_in,
  output logic signed [WIDTH-1:0] data_out [0:CHANNELS-1],
  output logic                    valid_out
);

  localparam int N         = FEATURE_SIZE * FEATURE_SIZE;
  localparam int ACC_W     = WIDTH + $clog2(N);
  localparam int PROD_W    = ACC_W + RECIP_SHIFT + 1;
  localparam int RECIP_INT = ((2 ** RECIP_SHIFT) + (N / 2)) / N;
  localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int PIX_W     = (N > 1) ? $clog2(N) : 1;

  localparam logic signed [PROD_W-1:0] RECIP = PROD_W'(RECIP_INT);
  localparam logic signed [PROD_W-1:0] ROUND = PROD_W'(2 ** (RECIP_SHIFT - 1));
  localparam logic signed [PROD_W-1:0] Q_MAX = PROD_W'((2 ** (WIDTH - 1)) - 1);
  localparam logic signed [PROD_W-1:0] Q_MIN = PROD_W'(-(2 ** (WIDTH - 1)));

  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    DIVIDE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t r_state;
  state_t w_stateNext;

  logic        [CH_W-1:0]   r_chCnt;
  logic        [PIX_W-1:0]  r_pixCnt;
  logic        [CH_W-1:0]   r_divIdx;
  logic signed [ACC_W-1:0]  r_acc [CHANNELS];

  logic                     w_transfer;
  logic                     w_lastCh;
  logic                     w_lastBeat;
  logic                     w_lastDiv;
  logic signed [ACC_W-1:0]  w_accSel;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [PROD_W-1:0] w_rounded;
  logic signed [PROD_W-1:0] w_shifted;
  logic signed [WIDTH-1:0]  w_q;

  assign ready_in   = en && (r_state == ACCUM);
  assign w_transfer = valid_in && ready_in;
  assign w_lastCh   = (r_chCnt == CH_W'(CHANNELS - 1));
  assign w_lastBeat = w_lastCh && (r_pixCnt == PIX_W'(N - 1));
  assign w_lastDiv  = (r_divIdx == CH_W'(CHANNELS - 1));

  // Round-half-up reciprocal division of the selected channel sum, saturated to the output range.
  always_comb begin
    w_accSel  = r_acc[r_divIdx];
    w_prod    = PROD_W'(w_accSel) * RECIP;
    w_rounded = w_prod + ROUND;
    w_shifted = w_rounded >>> RECIP_SHIFT;
    w_q       = w_shifted[WIDTH-1:0];
    if (w_shifted > Q_MAX) begin
      w_q = Q_MAX[WIDTH-1:0];
    end else if (w_shifted < Q_MIN) begin
      w_q = Q_MIN[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ACCUM;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    if (en) begin
      case (r_state)
        ACCUM:   if (w_transfer && w_lastBeat) w_stateNext = DIVIDE;
        DIVIDE:  if (w_lastDiv) w_stateNext = DONE;
        DONE:    w_stateNext = ACCUM;
        default: w_stateNext = ACCUM;
      endcase
    end
  end

  // The first pixel of a frame overwrites the accumulator, so no separate clear pass is needed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_chCnt   <= '0;
      r_pixCnt  <= '0;
      r_divIdx  <= '0;
      valid_out <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        r_acc[c]    <= '0;
        data_out[c] <= '0;
      end
    end else if (en) begin
      case (r_state)
        ACCUM: begin
          valid_out <= 1'b0;
          if (w_transfer) begin
            if (r_pixCnt == '0) begin
              r_acc[r_chCnt] <= ACC_W'(data_in);
            end else begin
              r_acc[r_chCnt] <= r_acc[r_chCnt] + ACC_W'(data_in);
            end
            if (w_lastBeat) begin
              r_chCnt  <= '0;
              r_pixCnt <= '0;
              r_divIdx <= '0;
            end else if (w_lastCh) begin
              r_chCnt  <= '0;
              r_pixCnt <= r_pixCnt + 1'b1;
            end else begin
              r_chCnt <= r_chCnt + 1'b1;
            end
          end
        end
        DIVIDE: begin
          data_out[r_divIdx] <= w_q;
          r_divIdx           <= w_lastDiv ? '0 : r_divIdx + 1'b1;
        end
        DONE: begin
          valid_out <= 1'b1;
        end
        default: begin
          valid_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_global_avg_pool_collect.sv
// Directed self-checking bench for global_avg_pool_collect at default parameters
// (64 channels, 7x7 spatial, Q8.8 samples).
module tb_global_avg_pool_collect;

  localparam int WIDTH    = 16;
  localparam int CHANNELS = 64;
  localparam int BEATS    = 49 * CHANNELS;

  logic                    clk;
  logic                    rst;
  logic                    en;
  logic signed [WIDTH-1:0] dataIn;
  logic                    validIn;
  logic                    readyIn;
  logic signed [WIDTH-1:0] dataOut [0:CHANNELS-1];
  logic                    validOut;

  int assertCount = 0;
  int failCount   = 0;
  int lat;

  global_avg_pool_collect dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .data_in   (dataIn),
    .valid_in  (validIn),
    .ready_in  (readyIn),
    .data_out  (dataOut),
    .valid_out (validOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic signed [31:0] obs,
                             input logic signed [31:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // mode 0: constant val; mode 1: channel c carries c*8; mode 2: +512 on even positions, -512 on odd
  task automatic applyStimulus(input int mode, input int val, input int nBeats,
                               input int pauseAt, input bit holdValid);
    int value;
    for (int b = 0; b < nBeats; b++) begin
      if (b == pauseAt) begin
        en = 1'b0;
        validIn = 1'b1;
        tick();
        checkOutput("pauseReady", readyIn, 0);
        repeat (9) tick();
        en = 1'b1;
      end
      case (mode)
        1:       value = (b % CHANNELS) * 8;
        2:       value = ((b / CHANNELS) % 2 == 0) ? 512 : -512;
        default: value = val;
      endcase
      dataIn  = WIDTH'(value);
      validIn = 1'b1;
      tick();
    end
    if (holdValid) begin
      dataIn = 16'sd999;
    end else begin
      validIn = 1'b0;
      dataIn  = '0;
    end
  endtask

  task automatic waitValid(output int cycles);
    cycles = 0;
    while (cycles < 300) begin
      tick();
      cycles++;
      if (validOut === 1'b1) break;
    end
  endtask

  task automatic checkFrame(input string tag, input int mode, input int val);
    for (int c = 0; c < CHANNELS; c++) begin
      checkOutput($sformatf("%s[%0d]", tag, c), dataOut[c], (mode == 1) ? c * 8 : val);
    end
  endtask

  initial begin
    rst     = 1'b1;
    en      = 1'b1;
    validIn = 1'b0;
    dataIn  = '0;
    tick();
    tick();
    checkOutput("rstReady", readyIn, 1);
    checkOutput("rstValid", validOut, 0);
    checkOutput("rstOut0", dataOut[0], 0);
    checkOutput("rstOut63", dataOut[63], 0);
    rst = 1'b0;

    $display("[TB] full frame of 1.0");
    applyStimulus(0, 256, BEATS, -1, 1'b0);
    checkOutput("t1ReadyLow", readyIn, 0);
    waitValid(lat);
    checkOutput("t1Latency", lat, 65);
    checkOutput("t1ReadyBack", readyIn, 1);
    checkFrame("t1Out", 0, 256);
    tick();
    checkOutput("t1PulseEnd", validOut, 0);

    $display("[TB] per-channel ramp");
    applyStimulus(1, 0, BEATS, -1, 1'b0);
    waitValid(lat);
    checkOutput("t2Latency", lat, 65);
    checkFrame("t2Out", 1, 0);
    checkOutput("t2Out63", dataOut[63], 504);

    $display("[TB] negative and alternating frames");
    applyStimulus(0, -256, BEATS, -1, 1'b0);
    waitValid(lat);
    checkOutput("t3aLatency", lat, 65);
    checkFrame("t3aOut", 0, -256);
    applyStimulus(2, 0, BEATS, -1, 1'b0);
    waitValid(lat);
    checkOutput("t3bLatency", lat, 65);
    checkFrame("t3bOut", 0, 10);

    $display("[TB] valid held through divide");
    applyStimulus(0, 256, BEATS, -1, 1'b1);
    waitValid(lat);
    checkOutput("t4aLatency", lat, 65);
    checkOutput("t4aOut5", dataOut[5], 256);
    applyStimulus(0, 128, BEATS, -1, 1'b0);
    waitValid(lat);
    checkOutput("t4bLatency", lat, 65);
    checkFrame("t4bOut", 0, 128);

    $display("[TB] reset mid-frame");
    applyStimulus(0, 256, 100, -1, 1'b0);
    rst     = 1'b1;
    validIn = 1'b1;
    dataIn  = 16'sd777;
    tick();
    rst     = 1'b0;
    validIn = 1'b0;
    checkOutput("t5Out0", dataOut[0], 0);
    checkOutput("t5Out63", dataOut[63], 0);
    checkOutput("t5Valid", validOut, 0);
    checkOutput("t5Ready", readyIn, 1);
    applyStimulus(0, 256, BEATS, -1, 1'b0);
    waitValid(lat);
    checkOutput("t5Latency", lat, 65);
    checkFrame("t5Out", 0, 256);

    $display("[TB] enable stalls");
    applyStimulus(0, 256, BEATS, 1000, 1'b0);
    repeat (5) tick();
    en = 1'b0;
    repeat (10) tick();
    checkOutput("t6StallValid", validOut, 0);
    checkOutput("t6StallReady", readyIn, 0);
    en = 1'b1;
    waitValid(lat);
    checkOutput("t6Latency", lat + 15, 75);
    checkFrame("t6Out", 0, 256);
    en = 1'b0;
    repeat (3) tick();
    checkOutput("t6Stretch", validOut, 1);
    en = 1'b1;
    tick();
    checkOutput("t6PulseEnd", validOut, 0);
    checkOutput("t6ReadyEnd", readyIn, 1);
    checkOutput("t6Held", dataOut[17], 256);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
